// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight predicted branches: allocated at fetch, resolved out of order
// by execute, retired at the head to train the BHT and to redirect fetch on a mispredict.
module branch_resolve_queue #(
    parameter int DEPTH = 8,
    localparam int TAGW = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alloc_valid,
    output logic            alloc_ready,
    input  logic [31:0]     alloc_pc,
    input  logic            alloc_pred_taken,
    input  logic [31:0]     alloc_pred_target,
    output logic [TAGW-1:0] alloc_tag,
    input  logic            ex_valid,
    input  logic [TAGW-1:0] ex_tag,
    input  logic            ex_taken,
    input  logic [31:0]     ex_target,
    output logic            resolve_valid,
    output logic [31:0]     resolve_pc,
    output logic            resolve_taken,
    output logic            redirect_valid,
    output logic [31:0]     redirect_pc,
    output logic [TAGW:0]   count,
    output logic [15:0]     mispredict_cnt
);

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_done;
    logic [DEPTH-1:0] r_predTaken;
    logic [DEPTH-1:0] r_actTaken;
    logic [31:0]      r_pc        [DEPTH];
    logic [31:0]      r_predTarget[DEPTH];
    logic [31:0]      r_actTarget [DEPTH];

    logic [TAGW-1:0]  r_head;
    logic [TAGW-1:0]  r_tail;
    logic [TAGW:0]    r_count;
    logic             r_resolveValid;
    logic [31:0]      r_resolvePc;
    logic             r_resolveTaken;
    logic             r_redirectValid;
    logic [31:0]      r_redirectPc;
    logic [15:0]      r_mispredictCnt;

    logic             w_alloc;
    logic             w_exWrite;
    logic             w_pop;
    logic             w_mispredict;
    logic             w_headPred;
    logic             w_headAct;
    logic [31:0]      w_headPc;
    logic [31:0]      w_headPredTarget;
    logic [31:0]      w_headActTarget;
    logic [TAGW:0]    w_countNext;

    assign alloc_ready = (r_count != (TAGW+1)'(DEPTH)) & ~r_redirectValid;
    assign w_alloc     = alloc_valid & alloc_ready;
    assign w_exWrite   = ex_valid & r_valid[ex_tag] & ~r_done[ex_tag];

    assign w_headPred       = r_predTaken[r_head];
    assign w_headAct        = r_actTaken[r_head];
    assign w_headPc         = r_pc[r_head];
    assign w_headPredTarget = r_predTarget[r_head];
    assign w_headActTarget  = r_actTarget[r_head];

    // Retirement looks only at registered state, so an ex write to the head retires a cycle later.
    assign w_pop        = r_valid[r_head] & r_done[r_head];
    assign w_mispredict = w_pop & ((w_headAct != w_headPred) |
                          (w_headAct & w_headPred & (w_headActTarget != w_headPredTarget)));

    always_comb begin
        w_countNext = r_count;
        case ({w_alloc, w_pop})
            2'b10:   w_countNext = r_count + (TAGW+1)'(1);
            2'b01:   w_countNext = r_count - (TAGW+1)'(1);
            default: w_countNext = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid         <= '0;
            r_done          <= '0;
            r_head          <= '0;
            r_tail          <= '0;
            r_count         <= '0;
            r_resolveValid  <= 1'b0;
            r_resolvePc     <= '0;
            r_resolveTaken  <= 1'b0;
            r_redirectValid <= 1'b0;
            r_redirectPc    <= '0;
            r_mispredictCnt <= '0;
        end else begin
            r_resolveValid  <= w_pop;
            r_redirectValid <= w_mispredict;
            if (w_pop) begin
                r_resolvePc    <= w_headPc;
                r_resolveTaken <= w_headAct;
            end
            if (w_mispredict) begin
                r_redirectPc    <= w_headAct ? w_headActTarget : w_headPc + 32'd4;
                r_mispredictCnt <= r_mispredictCnt + 16'd1;
                // Everything younger than the mispredicted branch is wrong-path work.
                r_valid <= '0;
                r_done  <= '0;
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_alloc) begin
                    r_valid[r_tail] <= 1'b1;
                    r_done[r_tail]  <= 1'b0;
                    r_tail          <= r_tail + TAGW'(1);
                end
                if (w_exWrite) begin
                    r_done[ex_tag] <= 1'b1;
                end
                if (w_pop) begin
                    r_valid[r_head] <= 1'b0;
                    r_head          <= r_head + TAGW'(1);
                end
                r_count <= w_countNext;
            end
        end
    end

    // Payload storage needs no reset; the valid/done bits qualify every read.
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_pc[r_tail]         <= alloc_pc;
            r_predTaken[r_tail]  <= alloc_pred_taken;
            r_predTarget[r_tail] <= alloc_pred_target;
        end
        if (w_exWrite) begin
            r_actTaken[ex_tag]  <= ex_taken;
            r_actTarget[ex_tag] <= ex_target;
        end
    end

    assign alloc_tag      = r_tail;
    assign resolve_valid  = r_resolveValid;
    assign resolve_pc     = r_resolvePc;
    assign resolve_taken  = r_resolveTaken;
    assign redirect_valid = r_redirectValid;
    assign redirect_pc    = r_redirectPc;
    assign count          = r_count;
    assign mispredict_cnt = r_mispredictCnt;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue: reset, in-order retirement, out-of-order resolution,
// mispredict flush/redirect and full-queue behaviour, checked with immediate assertions.
module tb_branch_resolve_queue;

    localparam int DEPTH = 8;
    localparam int TAGW  = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            alloc_valid = 1'b0;
    logic            alloc_ready;
    logic [31:0]     alloc_pc = '0;
    logic            alloc_pred_taken = 1'b0;
    logic [31:0]     alloc_pred_target = '0;
    logic [TAGW-1:0] alloc_tag;
    logic            ex_valid = 1'b0;
    logic [TAGW-1:0] ex_tag = '0;
    logic            ex_taken = 1'b0;
    logic [31:0]     ex_target = '0;
    logic            resolve_valid;
    logic [31:0]     resolve_pc;
    logic            resolve_taken;
    logic            redirect_valid;
    logic [31:0]     redirect_pc;
    logic [TAGW:0]   count;
    logic [15:0]     mispredict_cnt;

    int checks = 0;
    int errors = 0;

    branch_resolve_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_pc(alloc_pc),
        .alloc_pred_taken(alloc_pred_taken), .alloc_pred_target(alloc_pred_target),
        .alloc_tag(alloc_tag),
        .ex_valid(ex_valid), .ex_tag(ex_tag), .ex_taken(ex_taken), .ex_target(ex_target),
        .resolve_valid(resolve_valid), .resolve_pc(resolve_pc), .resolve_taken(resolve_taken),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .count(count), .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, observed, expected);
        end
    endtask

    // Drives one cycle of alloc/ex inputs, then samples 1 time unit after the rising edge.
    task automatic applyStimulus(input logic aV, input logic [31:0] aPc, input logic aT,
                                 input logic [31:0] aTgt, input logic eV,
                                 input logic [TAGW-1:0] eTag, input logic eT,
                                 input logic [31:0] eTgt);
        alloc_valid       = aV;
        alloc_pc          = aPc;
        alloc_pred_taken  = aT;
        alloc_pred_target = aTgt;
        ex_valid          = eV;
        ex_tag            = eTag;
        ex_taken          = eT;
        ex_target         = eTgt;
        @(posedge clk);
        #1;
        alloc_valid = 1'b0;
        ex_valid    = 1'b0;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, '0, 1'b0, 32'h0);
    endtask

    task automatic allocBranch(input logic [31:0] pc, input logic predT,
                               input logic [31:0] predTgt, input logic [TAGW-1:0] expTag);
        checkOutput("alloc_ready", alloc_ready, 1);
        checkOutput("alloc_tag", alloc_tag, expTag);
        applyStimulus(1'b1, pc, predT, predTgt, 1'b0, '0, 1'b0, 32'h0);
    endtask

    task automatic exBranch(input logic [TAGW-1:0] tag, input logic taken,
                            input logic [31:0] tgt);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, tag, taken, tgt);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst count", count, 0);
        checkOutput("rst alloc_ready", alloc_ready, 1);
        checkOutput("rst resolve_valid", resolve_valid, 0);
        checkOutput("rst redirect_valid", redirect_valid, 0);
        checkOutput("rst redirect_pc", redirect_pc, 0);
        checkOutput("rst mispredict_cnt", mispredict_cnt, 0);
        rst_n = 1'b1;

        // Reset in the middle of operation drops all three entries immediately.
        allocBranch(32'h10, 1'b0, 32'h0, 3'd0);
        allocBranch(32'h14, 1'b0, 32'h0, 3'd1);
        allocBranch(32'h18, 1'b0, 32'h0, 3'd2);
        checkOutput("t1 count before reset", count, 3);
        rst_n = 1'b0;
        #1;
        checkOutput("t1 async count", count, 0);
        checkOutput("t1 async alloc_ready", alloc_ready, 1);
        idle();
        rst_n = 1'b1;
        exBranch(3'd0, 1'b0, 32'h0);
        checkOutput("t1 resolve_valid a", resolve_valid, 0);
        idle();
        checkOutput("t1 resolve_valid b", resolve_valid, 0);
        checkOutput("t1 redirect_valid", redirect_valid, 0);
        checkOutput("t1 count after", count, 0);

        // In-order resolution, all predicted correctly not-taken.
        allocBranch(32'h100, 1'b0, 32'h0, 3'd0);
        allocBranch(32'h104, 1'b0, 32'h0, 3'd1);
        allocBranch(32'h108, 1'b0, 32'h0, 3'd2);
        exBranch(3'd0, 1'b0, 32'h0);
        checkOutput("t2 latency", resolve_valid, 0);
        exBranch(3'd1, 1'b0, 32'h0);
        checkOutput("t2 rv0", resolve_valid, 1);
        checkOutput("t2 pc0", resolve_pc, 32'h100);
        checkOutput("t2 taken0", resolve_taken, 0);
        checkOutput("t2 redirect0", redirect_valid, 0);
        exBranch(3'd2, 1'b0, 32'h0);
        checkOutput("t2 rv1", resolve_valid, 1);
        checkOutput("t2 pc1", resolve_pc, 32'h104);
        idle();
        checkOutput("t2 rv2", resolve_valid, 1);
        checkOutput("t2 pc2", resolve_pc, 32'h108);
        idle();
        checkOutput("t2 rv end", resolve_valid, 0);
        checkOutput("t2 count end", count, 0);

        // Out-of-order resolution still retires in program order.
        allocBranch(32'h100, 1'b0, 32'h0, 3'd3);
        allocBranch(32'h104, 1'b0, 32'h0, 3'd4);
        allocBranch(32'h108, 1'b0, 32'h0, 3'd5);
        exBranch(3'd5, 1'b0, 32'h0);
        checkOutput("t3 rv a", resolve_valid, 0);
        exBranch(3'd3, 1'b0, 32'h0);
        checkOutput("t3 rv b", resolve_valid, 0);
        exBranch(3'd4, 1'b0, 32'h0);
        checkOutput("t3 pc0", resolve_pc, 32'h100);
        checkOutput("t3 rv0", resolve_valid, 1);
        idle();
        checkOutput("t3 pc1", resolve_pc, 32'h104);
        checkOutput("t3 rv1", resolve_valid, 1);
        idle();
        checkOutput("t3 pc2", resolve_pc, 32'h108);
        checkOutput("t3 rv2", resolve_valid, 1);
        idle();
        checkOutput("t3 rv end", resolve_valid, 0);

        // Mispredicted direction: flush, discard the same-cycle alloc and ex write.
        allocBranch(32'h200, 1'b0, 32'h0, 3'd6);
        allocBranch(32'h204, 1'b0, 32'h0, 3'd7);
        allocBranch(32'h208, 1'b0, 32'h0, 3'd0);
        exBranch(3'd6, 1'b1, 32'h400);
        checkOutput("t4 rv early", resolve_valid, 0);
        applyStimulus(1'b1, 32'h999, 1'b0, 32'h0, 1'b1, 3'd7, 1'b0, 32'h0);
        checkOutput("t4 rv", resolve_valid, 1);
        checkOutput("t4 resolve_pc", resolve_pc, 32'h200);
        checkOutput("t4 resolve_taken", resolve_taken, 1);
        checkOutput("t4 redirect_valid", redirect_valid, 1);
        checkOutput("t4 redirect_pc", redirect_pc, 32'h400);
        checkOutput("t4 count", count, 0);
        checkOutput("t4 mispredict_cnt", mispredict_cnt, 1);
        checkOutput("t4 alloc_ready blocked", alloc_ready, 0);
        exBranch(3'd7, 1'b0, 32'h0);
        checkOutput("t4 redirect one cycle", redirect_valid, 0);
        checkOutput("t4 rv one cycle", resolve_valid, 0);
        checkOutput("t4 count after", count, 0);
        idle();
        checkOutput("t4 younger ignored", resolve_valid, 0);

        // Wrong target on a taken prediction, then taken predicted but not taken.
        allocBranch(32'h280, 1'b1, 32'h300, 3'd0);
        exBranch(3'd0, 1'b1, 32'h310);
        idle();
        checkOutput("t5 redirect_valid a", redirect_valid, 1);
        checkOutput("t5 redirect_pc a", redirect_pc, 32'h310);
        checkOutput("t5 resolve_pc a", resolve_pc, 32'h280);
        checkOutput("t5 mispredict_cnt a", mispredict_cnt, 2);
        idle();
        allocBranch(32'h500, 1'b1, 32'h600, 3'd0);
        exBranch(3'd0, 1'b0, 32'h0);
        idle();
        checkOutput("t5 redirect_valid b", redirect_valid, 1);
        checkOutput("t5 redirect_pc b", redirect_pc, 32'h504);
        checkOutput("t5 resolve_taken b", resolve_taken, 0);
        checkOutput("t5 mispredict_cnt b", mispredict_cnt, 3);
        idle();
        allocBranch(32'h700, 1'b1, 32'h800, 3'd0);
        exBranch(3'd0, 1'b1, 32'h800);
        idle();
        checkOutput("t5 correct rv", resolve_valid, 1);
        checkOutput("t5 correct pc", resolve_pc, 32'h700);
        checkOutput("t5 correct taken", resolve_taken, 1);
        checkOutput("t5 correct no redirect", redirect_valid, 0);
        checkOutput("t5 correct cnt", mispredict_cnt, 3);
        idle();

        // Fill all entries, tail wraps, no alloc while full even alongside a pop.
        for (int i = 0; i < DEPTH; i++) begin
            allocBranch(32'(32'h1000 + 4 * i), 1'b0, 32'h0, 3'((1 + i) % DEPTH));
        end
        checkOutput("t6 count full", count, 8);
        checkOutput("t6 alloc_ready full", alloc_ready, 0);
        checkOutput("t6 tail wrapped", alloc_tag, 1);
        exBranch(3'd1, 1'b0, 32'h0);
        applyStimulus(1'b1, 32'hDEAD, 1'b0, 32'h0, 1'b0, '0, 1'b0, 32'h0);
        checkOutput("t6 pop pc", resolve_pc, 32'h1000);
        checkOutput("t6 count no alloc", count, 7);
        for (int k = 2; k <= DEPTH; k++) begin
            exBranch(3'(k % DEPTH), 1'b0, 32'h0);
            if (k == 2) begin
                checkOutput("t6 rv gap", resolve_valid, 0);
            end else begin
                checkOutput("t6 rv", resolve_valid, 1);
                checkOutput("t6 pc", resolve_pc, 32'(32'h1000 + 4 * (k - 2)));
            end
        end
        idle();
        checkOutput("t6 last pc", resolve_pc, 32'h101C);
        checkOutput("t6 last rv", resolve_valid, 1);
        idle();
        checkOutput("t6 count empty", count, 0);
        checkOutput("t6 rv empty", resolve_valid, 0);
        checkOutput("t6 mispredict_cnt", mispredict_cnt, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
